int_to_fp: RTL and testbench
============================

# int_to_fp

Sequential integer-to-floating-point converter feeding the fp adder's operand ports. Accepts a signed two's-complement integer over a valid/ready handshake and normalizes it iteratively, one left shift per cycle. It emits the sign / 4-bit exponent / 8-bit fraction triple the adder consumes. Value encoding is 0.frac × 2^exp, with frac[7] = 1 for every nonzero result and exp = 0, frac = 0 for zero.

## Interface
- IN_W, 16, integer input width; IN_W ≤ 2^EXP_W
- EXP_W, 4, exponent width
- FRAC_W, 8, fraction width; FRAC_W ≤ IN_W
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high
- in_valid  in  1  input integer present
- in_ready  out  1  converter idle and able to accept
- in_data  in  IN_W  signed two's-complement integer
- out_valid  out  1  result held on outputs
- out_ready  in  1  consumer takes result
- sign_out  out  1  result sign
- exp_out  out  EXP_W  result exponent
- frac_out  out  FRAC_W  normalized fraction, truncated
- ovf_out  out  1  magnitude exceeded format; result saturated

## Operation
- Single clock domain. Reset is synchronous and active-high.
- States:
  - IDLE: in_ready = 1.
  - SHIFT: normalizing.
  - DONE: out_valid = 1.
- IDLE, on in_valid & in_ready:
  - sign_r <= in_data[IN_W-1].
  - mag_r <= |in_data|, an IN_W-bit unsigned value; -2^(IN_W-1) gives 2^(IN_W-1).
  - cnt_r <= IN_W, held as EXP_W+1 bits.
  - Go to SHIFT.
- SHIFT, one action per cycle, in this priority:
  1. mag_r == 0: outputs all zero, sign_out = 0, ovf_out = 0; go to DONE.
  2. mag_r[IN_W-1] == 1 and cnt_r > 2^EXP_W - 1: sign_out = sign_r, exp_out = all ones, frac_out = all ones, ovf_out = 1; go to DONE.
  3. mag_r[IN_W-1] == 1: sign_out = sign_r, exp_out = cnt_r[EXP_W-1:0], frac_out = mag_r[IN_W-1 -: FRAC_W], ovf_out = 0; go to DONE.
  4. Otherwise: mag_r <= mag_r << 1, cnt_r <= cnt_r - 1; stay in SHIFT.
- Rounding: dropped low bits are truncated, with no rounding. This matches the adder.
- DONE: outputs are stable while out_valid & !out_ready. On out_valid & out_ready, go to IDLE.
- No overlap: in_ready = 0 in SHIFT and DONE.

## Timing
- Reset values:
  - state = IDLE.
  - out_valid, sign_out, exp_out, frac_out, ovf_out = 0.
  - in_ready = 0 while reset is asserted, 1 on the first cycle after release.
- in_ready and out_valid are decoded directly from registered state, with no combinational path from in_valid or out_ready.
- Latency: out_valid rises lz+1 cycles after the accept edge, where lz is the leading-zero count of the IN_W-bit magnitude.
  - Zero input: 1 cycle.
  - Input 1 at IN_W = 16: 16 cycles, the worst case.
- in_ready returns 1 on the cycle after the output handshake. Minimum spacing between accepts is lz+3 cycles.
- Reset during SHIFT or DONE aborts the conversion. Next cycle: IDLE, out_valid = 0, pending result discarded.
- in_valid asserted outside IDLE is ignored. in_data is sampled only at the accept edge.
- out_ready outside DONE has no effect.

## Structure
- Shared package fp_pkg holds:
  - EXP_W and FRAC_W constants, shared with the adder.
  - fp_t packed struct {sign, exp, frac}.
  - Converter state enum {IDLE, SHIFT, DONE}.
- One module, no sub-module. The shifter is a single register with the counter beside it.

## Test plan
- in_data = 16'd1 → out_valid 16 cycles after accept; sign 0, exp 1, frac 8'h80, ovf 0.
- in_data = 16'd300 (0x012C) → latency 8; sign 0, exp 9, frac 8'h96.
- in_data = -5 (0xFFFB) → latency 14; sign 1, exp 3, frac 8'hA0.
- in_data = 0 → latency 1; sign 0, exp 0, frac 0, ovf 0.
- in_data = 32767 → exp 4'hF, frac 8'hFF, ovf 0.
- in_data = -32768 → sign 1, exp 4'hF, frac 8'hFF, ovf 1.
- Backpressure: hold out_ready low for 5 cycles in DONE → outputs unchanged, in_ready 0. Raise out_ready → IDLE next cycle.
- Reset pulse mid-SHIFT (in_data = 1, 5th cycle) → IDLE next cycle, out_valid never asserts. A subsequent in_data = 300 converts correctly.

Source files
------------

// File: rtl/fp_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fp_pkg
//  Description : Shared floating-point definitions for the fp adder and the
//                integer-to-fp converter.
//                - Exponent and fraction widths.
//                - Operand triple {sign, exp, frac}.
//                - Converter state encoding.
//  Revision    : 1.0  initial release
// ============================================================================
package fp_pkg;

    localparam int EXP_W  = 4;
    localparam int FRAC_W = 8;

    // Operand format consumed by the adder: value = 0.frac x 2^exp
    typedef struct packed {
        logic              sign;
        logic [EXP_W-1:0]  exp;
        logic [FRAC_W-1:0] frac;
    } fp_t;

    // Converter state encoding
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } conv_state_t;

endpackage
`default_nettype wire

// File: rtl/int_to_fp_if.sv
`default_nettype none
// ============================================================================
//  Module      : int_to_fp_if
//  Description : Handshake bundle between an integer producer and the
//                int_to_fp converter.
//                - Input side: in_valid / in_ready / in_data.
//                - Output side: out_valid / out_ready plus the fp triple and
//                  the overflow flag.
//  Revision    : 1.0  initial release
// ============================================================================
interface int_to_fp_if #(
    parameter int IN_W   = 16,
    parameter int EXP_W  = fp_pkg::EXP_W,
    parameter int FRAC_W = fp_pkg::FRAC_W
);
    import fp_pkg::*;

    logic              in_valid;
    logic              in_ready;
    logic [IN_W-1:0]   in_data;
    logic              out_valid;
    logic              out_ready;
    logic              sign_out;
    logic [EXP_W-1:0]  exp_out;
    logic [FRAC_W-1:0] frac_out;
    logic              ovf_out;

    // Producer / consumer side
    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, sign_out, exp_out, frac_out, ovf_out
    );

    // Converter side
    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, sign_out, exp_out, frac_out, ovf_out
    );

endinterface
`default_nettype wire

// File: rtl/int_to_fp.sv
`default_nettype none
// ============================================================================
//  Module      : int_to_fp
//  Description : Sequential signed-integer to floating-point converter.
//                - Takes the magnitude of the input.
//                - Normalizes it one left shift per cycle, decrementing the
//                  exponent counter alongside.
//                - Holds the truncated result until the consumer takes it.
//                - Magnitudes beyond the exponent range saturate and flag
//                  overflow.
//  Revision    : 1.0  initial release
// ============================================================================
module int_to_fp #(
    parameter int IN_W   = 16,
    parameter int EXP_W  = fp_pkg::EXP_W,
    parameter int FRAC_W = fp_pkg::FRAC_W
) (
    input  wire logic   clk,
    input  wire logic   reset,
    int_to_fp_if.slave  bus
);
    import fp_pkg::*;

    localparam int                c_cnt_w    = EXP_W + 1;
    localparam logic [c_cnt_w-1:0] c_cnt_init = c_cnt_w'(IN_W);
    localparam logic [c_cnt_w-1:0] c_exp_max  = c_cnt_w'((1 << EXP_W) - 1);

    conv_state_t       r_state;
    logic              r_sign_in;
    logic [IN_W-1:0]   r_mag;
    logic [c_cnt_w-1:0] r_cnt;
    logic              r_sign;
    logic [EXP_W-1:0]  r_exp;
    logic [FRAC_W-1:0] r_frac;
    logic              r_ovf;
    logic [IN_W-1:0]   w_in_mag;

    // Absolute value of the incoming integer; the most negative value maps to 2^(IN_W-1)
    always_comb begin
        w_in_mag = bus.in_data;
        if (bus.in_data[IN_W-1]) begin
            w_in_mag = ~bus.in_data + IN_W'(1);
        end
    end

    // Handshake flags come straight from state; in_ready is held low during reset
    assign bus.in_ready  = (r_state == IDLE) && !reset;
    assign bus.out_valid = (r_state == DONE);
    assign bus.sign_out  = r_sign;
    assign bus.exp_out   = r_exp;
    assign bus.frac_out  = r_frac;
    assign bus.ovf_out   = r_ovf;

    // Accept, normalize one bit per cycle, then hold the result until taken
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= IDLE;
            r_sign_in <= 1'b0;
            r_mag     <= '0;
            r_cnt     <= c_cnt_init;
            r_sign    <= 1'b0;
            r_exp     <= '0;
            r_frac    <= '0;
            r_ovf     <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.in_valid) begin
                        r_sign_in <= bus.in_data[IN_W-1];
                        r_mag     <= w_in_mag;
                        r_cnt     <= c_cnt_init;
                        r_state   <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (r_mag == '0) begin
                        // Zero has no leading one: emit the all-zero encoding
                        r_sign  <= 1'b0;
                        r_exp   <= '0;
                        r_frac  <= '0;
                        r_ovf   <= 1'b0;
                        r_state <= DONE;
                    end else if (r_mag[IN_W-1]) begin
                        r_sign  <= r_sign_in;
                        r_state <= DONE;
                        if (r_cnt > c_exp_max) begin
                            // Exponent does not fit: saturate to the largest magnitude
                            r_exp  <= '1;
                            r_frac <= '1;
                            r_ovf  <= 1'b1;
                        end else begin
                            // Low bits below the fraction are dropped (truncation)
                            r_exp  <= r_cnt[EXP_W-1:0];
                            r_frac <= r_mag[IN_W-1 -: FRAC_W];
                            r_ovf  <= 1'b0;
                        end
                    end else begin
                        r_mag <= r_mag << 1;
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        r_state <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_int_to_fp.sv
`default_nettype none
// ============================================================================
//  Module      : tb_int_to_fp
//  Description : Directed self-checking bench for int_to_fp.
//                - Reset state and release.
//                - Conversion vectors with hand-computed results and latency.
//                - Backpressure hold with ignored in_valid.
//                - Reset abort mid-normalization, then recovery.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_int_to_fp;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    int_to_fp_if #(.IN_W(16), .EXP_W(4), .FRAC_W(8)) bus ();

    int_to_fp #(.IN_W(16), .EXP_W(4), .FRAC_W(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Advance to just after the next rising edge
    task automatic wait_cycle();
        @(posedge clk);
        #1;
    endtask

    // Present one integer for a single accept edge, then count cycles until out_valid
    task automatic convert(input logic [15:0] data, output int lat);
        bus.in_data  = data;
        bus.in_valid = 1'b1;
        wait_cycle();
        bus.in_valid = 1'b0;
        bus.in_data  = 16'hA5A5;
        lat = 0;
        while (!bus.out_valid && lat < 40) begin
            wait_cycle();
            lat++;
        end
        if (!bus.out_valid) lat = -1;
    endtask

    task automatic test_reset();
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;
        repeat (3) wait_cycle();
        n_cmp++;
        if (bus.in_ready !== 1'b0) begin
            n_err++;
            $display("FAIL reset_in_ready_held: got %b expected 0", bus.in_ready);
        end
        reset = 1'b0;
        #1;
        n_cmp++;
        if (bus.in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL reset_in_ready_release: got %b expected 1", bus.in_ready);
        end
        n_cmp++;
        if ({bus.out_valid, bus.sign_out, bus.exp_out, bus.frac_out, bus.ovf_out} !== 15'h0) begin
            n_err++;
            $display("FAIL reset_outputs: got %h expected 0",
                     {bus.out_valid, bus.sign_out, bus.exp_out, bus.frac_out, bus.ovf_out});
        end
    endtask

    task automatic test_vectors();
        logic [15:0] v_data [9] = '{16'h0001, 16'h012C, 16'hFFFB, 16'h0000, 16'h7FFF,
                                    16'h8000, 16'h0000, 16'hFFFF, 16'h01FF};
        int          v_lat  [9] = '{16, 8, 14, 1, 2, 1, 1, 16, 8};
        // {sign, exp, frac, ovf}
        logic [13:0] v_res  [9] = '{{1'b0, 4'h1, 8'h80, 1'b0}, {1'b0, 4'h9, 8'h96, 1'b0},
                                    {1'b1, 4'h3, 8'hA0, 1'b0}, {1'b0, 4'h0, 8'h00, 1'b0},
                                    {1'b0, 4'hF, 8'hFF, 1'b0}, {1'b1, 4'hF, 8'hFF, 1'b1},
                                    {1'b0, 4'h0, 8'h00, 1'b0}, {1'b1, 4'h1, 8'h80, 1'b0},
                                    {1'b0, 4'h9, 8'hFF, 1'b0}};
        int          lat;
        logic [13:0] got;
        for (int i = 0; i < 9; i++) begin
            n_cmp++;
            if (bus.in_ready !== 1'b1) begin
                n_err++;
                $display("FAIL vec%0d_in_ready_before: got %b expected 1", i, bus.in_ready);
            end
            convert(v_data[i], lat);
            n_cmp++;
            if (lat !== v_lat[i]) begin
                n_err++;
                $display("FAIL vec%0d_latency data=%h: got %0d expected %0d", i, v_data[i], lat, v_lat[i]);
            end
            got = {bus.sign_out, bus.exp_out, bus.frac_out, bus.ovf_out};
            n_cmp++;
            if (got !== v_res[i]) begin
                n_err++;
                $display("FAIL vec%0d_result data=%h: got s/e/f/o=%b/%h/%h/%b expected %b/%h/%h/%b",
                         i, v_data[i], got[13], got[12:9], got[8:1], got[0],
                         v_res[i][13], v_res[i][12:9], v_res[i][8:1], v_res[i][0]);
            end
            bus.out_ready = 1'b1;
            wait_cycle();
            bus.out_ready = 1'b0;
            n_cmp++;
            if ({bus.in_ready, bus.out_valid} !== 2'b10) begin
                n_err++;
                $display("FAIL vec%0d_release: got ready/valid=%b%b expected 10",
                         i, bus.in_ready, bus.out_valid);
            end
        end
    endtask

    task automatic test_backpressure();
        int lat;
        convert(16'h012C, lat);
        n_cmp++;
        if (lat !== 8) begin
            n_err++;
            $display("FAIL bp_latency: got %0d expected 8", lat);
        end
        // A new integer offered while the result is held must be ignored
        bus.in_valid = 1'b1;
        bus.in_data  = 16'h0001;
        for (int c = 0; c < 5; c++) begin
            wait_cycle();
            n_cmp++;
            if ({bus.out_valid, bus.in_ready, bus.sign_out, bus.exp_out, bus.frac_out, bus.ovf_out}
                    !== {1'b1, 1'b0, 1'b0, 4'h9, 8'h96, 1'b0}) begin
                n_err++;
                $display("FAIL bp_hold cycle %0d: got v/r/s/e/f/o=%b/%b/%b/%h/%h/%b expected 1/0/0/9/96/0",
                         c, bus.out_valid, bus.in_ready, bus.sign_out, bus.exp_out, bus.frac_out, bus.ovf_out);
            end
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        wait_cycle();
        bus.out_ready = 1'b0;
        n_cmp++;
        if ({bus.in_ready, bus.out_valid} !== 2'b10) begin
            n_err++;
            $display("FAIL bp_release: got ready/valid=%b%b expected 10", bus.in_ready, bus.out_valid);
        end
    endtask

    task automatic test_reset_mid_shift();
        int   lat;
        logic seen_valid;
        bus.in_data  = 16'h0001;
        bus.in_valid = 1'b1;
        wait_cycle();
        bus.in_valid = 1'b0;
        repeat (4) wait_cycle();
        reset = 1'b1;
        wait_cycle();
        reset = 1'b0;
        #1;
        n_cmp++;
        if ({bus.in_ready, bus.out_valid, bus.sign_out, bus.exp_out, bus.frac_out, bus.ovf_out} !== 16'h8000) begin
            n_err++;
            $display("FAIL abort_state: got r/v/s/e/f/o=%b/%b/%b/%h/%h/%b expected 1/0/0/0/00/0",
                     bus.in_ready, bus.out_valid, bus.sign_out, bus.exp_out, bus.frac_out, bus.ovf_out);
        end
        seen_valid = 1'b0;
        repeat (20) begin
            wait_cycle();
            if (bus.out_valid) seen_valid = 1'b1;
        end
        n_cmp++;
        if (seen_valid !== 1'b0) begin
            n_err++;
            $display("FAIL abort_no_output: got out_valid seen=%b expected 0", seen_valid);
        end
        convert(16'h012C, lat);
        n_cmp++;
        if (lat !== 8) begin
            n_err++;
            $display("FAIL abort_recover_latency: got %0d expected 8", lat);
        end
        n_cmp++;
        if ({bus.sign_out, bus.exp_out, bus.frac_out, bus.ovf_out} !== {1'b0, 4'h9, 8'h96, 1'b0}) begin
            n_err++;
            $display("FAIL abort_recover_result: got s/e/f/o=%b/%h/%h/%b expected 0/9/96/0",
                     bus.sign_out, bus.exp_out, bus.frac_out, bus.ovf_out);
        end
        bus.out_ready = 1'b1;
        wait_cycle();
        bus.out_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_vectors();
        test_backpressure();
        test_reset_mid_shift();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    // Global time bound so the run always ends
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
